// File: rtl/jk_excite_drv_311.sv
// Excitation driver for a bank of JK flip-flops: snapshots a target word, pulses J/K
// for one cycle, waits SETTLE cycles, then compares the bank's Q against the target.
module jk_excite_drv_311 #(
    parameter int WIDTH   = 4,
    parameter int SETTLE  = 1,
    parameter int DC_MODE = 0
) (
    input  logic             clk_311,
    input  logic             reset,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_mask,
    output logic [7:0]       err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT
    } state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [7:0]       ecnt_q, ecnt_d;

    logic [WIDTH-1:0] exc_j, exc_k;
    logic             settle_last;

    // Q0 is only needed on the capture edge, where it is folded straight into J/K,
    // so the registered J/K already act as the snapshot of the bank state.
    generate
        if (DC_MODE == 0) begin : g_minimal
            assign exc_j = tgt_data & ~q_fb;
            assign exc_k = ~tgt_data & q_fb;
        end else begin : g_forced
            assign exc_j = tgt_data;
            assign exc_k = ~tgt_data;
        end
    endgenerate

    assign settle_last = (cnt_q == 4'd1);

    // State register
    always_ff @(posedge clk_311 or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of process evaluation order.
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: assign a default before the case so no path leaves a variable
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (tgt_valid) state_d = ST_DRIVE;
            ST_DRIVE: state_d = ST_WAIT;
            ST_WAIT:  if (settle_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        tgt_ready = (state_q == ST_IDLE);
    end

    // Datapath next-state: J/K are zero in every cycle except the one after capture
    always_comb begin
        tgt_d  = tgt_q;
        j_d    = '0;
        k_d    = '0;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        err_d  = err_q;
        mask_d = mask_q;
        ecnt_d = ecnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (tgt_valid) begin
                    tgt_d = tgt_data;
                    j_d   = exc_j;
                    k_d   = exc_k;
                end
            end
            ST_DRIVE: begin
                cnt_d = SETTLE_CNT;
            end
            ST_WAIT: begin
                if (settle_last) begin
                    mask_d = q_fb ^ tgt_q;
                    err_d  = |mask_d;
                    done_d = 1'b1;
                    if (err_d && (ecnt_q != 8'hFF)) begin
                        ecnt_d = ecnt_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_311 or negedge reset) begin
        if (!reset) begin
            tgt_q  <= '0;
            j_q    <= '0;
            k_q    <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            mask_q <= '0;
            ecnt_q <= '0;
        end else begin
            tgt_q  <= tgt_d;
            j_q    <= j_d;
            k_q    <= k_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            err_q  <= err_d;
            mask_q <= mask_d;
            ecnt_q <= ecnt_d;
        end
    end

    assign j_out    = j_q;
    assign k_out    = k_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_mask = mask_q;
    assign err_cnt  = ecnt_q;

endmodule
